// File: rtl/uart_instr_loader_pkg.sv
// Shared constants and receiver state encoding for the UART instruction loader.
package uart_instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned DEF_CLK_FREQ   = 50_000_000;
    localparam int unsigned DEF_BAUD       = 115_200;
    localparam int unsigned CLKS_PER_BIT   = DEF_CLK_FREQ / DEF_BAUD;
    localparam int unsigned HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 16;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_instr_loader_if.sv
// Instruction-memory write port plus loader status, as seen by the fetch side.
interface uart_instr_loader_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              frame_err;
    logic              overflow;

    modport master (
        output imem_we, imem_addr, imem_wdata, word_count, busy, frame_err, overflow
    );

    modport slave (
        input imem_we, imem_addr, imem_wdata, word_count, busy, frame_err, overflow
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rxd synchronizer, framing FSM and bit-period counter.
module uart_rx_byte
    import uart_instr_loader_pkg::*;
#(
    parameter int unsigned CPB = CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int unsigned HALF = CPB / 2;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d, rx_byte_d;
    logic             rxd_meta, rxd_s;
    logic             armed_q, armed_d;
    logic             valid_d, err_d;

    // Synchronizer resets low so a line held low across reset never looks idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b0;
            rxd_s    <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            armed_q    <= armed_d;
            rx_byte    <= rx_byte_d;
            byte_valid <= valid_d;
            stop_err   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        armed_d   = armed_q | rxd_s;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable && armed_q && !rxd_s) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CPB - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        valid_d   = 1'b1;
                        rx_byte_d = shift_q;
                    end else begin
                        // Line is still low; wait for it to go high before the next start.
                        err_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

endmodule

// File: rtl/uart_instr_loader.sv
// Serial boot loader: packs received UART bytes into 32-bit words for instruction memory.
module uart_instr_loader
    import uart_instr_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                rxd,
    uart_instr_loader_if.master imem
);

    localparam int unsigned CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned WC_W    = ADDR_W + 1;
    localparam int unsigned WC_MAX  = 2 ** ADDR_W;

    logic [7:0]        rx_byte;
    logic              byte_valid, stop_err;
    logic              en_meta, en_sync, en_prev;
    logic              en_rise, accept, word_done;
    logic [1:0]        byte_idx_q;
    logic [23:0]       buf_q;
    logic [ADDR_W-1:0] ptr_q, addr_q;
    logic [WC_W-1:0]   count_q;
    logic [31:0]       wdata_q;
    logic              we_q, busy_q, ferr_q, ovf_q;

    uart_rx_byte #(.CPB(CPB)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .enable     (en_sync),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    assign en_rise   = en_sync & ~en_prev;
    assign accept    = byte_valid & en_sync;
    assign word_done = accept & (byte_idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_meta <= 1'b0;
            en_sync <= 1'b0;
            en_prev <= 1'b0;
        end else begin
            en_meta <= enable;
            en_sync <= en_meta;
            en_prev <= en_sync;
        end
    end

    // Write port and busy are registered from the word-complete condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q   <= word_done;
            busy_q <= en_sync | word_done;
            if (word_done) begin
                addr_q  <= ptr_q;
                wdata_q <= {rx_byte, buf_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= '0;
            buf_q      <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (en_rise) begin
            byte_idx_q <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!en_sync) begin
            byte_idx_q <= '0;
        end else begin
            if (stop_err) ferr_q <= 1'b1;
            if (accept) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0:    buf_q[7:0]   <= rx_byte;
                    2'd1:    buf_q[15:8]  <= rx_byte;
                    2'd2:    buf_q[23:16] <= rx_byte;
                    default: ;
                endcase
            end
            if (word_done) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) ovf_q <= 1'b1;
                if (count_q != WC_W'(WC_MAX)) count_q <= count_q + WC_W'(1);
            end
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign imem.word_count = count_q;
    assign imem.busy       = busy_q;
    assign imem.frame_err  = ferr_q;
    assign imem.overflow   = ovf_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: full-size and 2-bit-address instances on one serial line.
module tb_uart_instr_loader;

    localparam int unsigned CLK_FREQ = 320_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned CPB      = 32;
    localparam int unsigned HALF     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic rxd = 1'b1;

    always #5 clk = ~clk;

    uart_instr_loader_if #(.ADDR_W(8)) bus ();
    uart_instr_loader_if #(.ADDR_W(2)) bus_s ();

    uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(8)) dut (
        .clk    (clk),
        .rst    (rst_n),
        .enable (enable),
        .rxd    (rxd),
        .imem   (bus)
    );

    uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(2)) dut_s (
        .clk    (clk),
        .rst    (rst_n),
        .enable (enable),
        .rxd    (rxd),
        .imem   (bus_s)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int unsigned stop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write logs for both instances, sampled mid-cycle.
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int unsigned wt_q[$];
    logic [1:0]  sa_q[$];
    logic [31:0] sd_q[$];
    int          back2back = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
            wt_q.push_back(cyc);
            if (prev_we) back2back++;
        end
        prev_we = bus.imem_we;
        if (bus_s.imem_we) begin
            sa_q.push_back(bus_s.imem_addr);
            sd_q.push_back(bus_s.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wt_q.delete();
        sa_q.delete(); sd_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        stop_cyc = cyc;
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        clear_logs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(bus.imem_we),    64'h0);
        check({tag, "_addr"},  64'(bus.imem_addr),  64'h0);
        check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'h0);
        check({tag, "_wc"},    64'(bus.word_count), 64'h0);
        check({tag, "_busy"},  64'(bus.busy),       64'h0);
        check({tag, "_ferr"},  64'(bus.frame_err),  64'h0);
        check({tag, "_ovf"},   64'(bus.overflow),   64'h0);
    endtask

    function automatic logic lat_ok();
        int unsigned d;
        d = wt_q[wt_q.size()-1] - stop_cyc;
        return (d >= HALF) && (d <= HALF + 6);
    endfunction

    initial begin
        int unsigned diff;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("busy_en", 64'(bus.busy), 64'h1);

        // First word: little-endian packing of 13 00 20 00.
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        repeat (4) @(negedge clk);
        check("t1_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t1_addr", 64'(wa_q[0]), 64'h0);
            check("t1_data", 64'(wd_q[0]), 64'h0020_0013);
            check("t1_lat",  64'(lat_ok()), 64'h1);
        end
        check("t1_wc", 64'(bus.word_count), 64'd1);

        // Two consecutive words.
        restart();
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        check("t2_nwr", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            check("t2_addr0", 64'(wa_q[0]), 64'h0);
            check("t2_data0", 64'(wd_q[0]), 64'h1234_5678);
            check("t2_addr1", 64'(wa_q[1]), 64'h1);
            check("t2_data1", 64'(wd_q[1]), 64'hDEAD_BEEF);
            check("t2_lat",   64'(lat_ok()), 64'h1);
        end
        check("t2_wc", 64'(bus.word_count), 64'd2);
        check("t2_we_width", 64'(back2back), 64'd0);

        // Short low glitch in idle must not start a frame.
        clear_logs();
        rxd = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("t3_nwr", 64'(wa_q.size()), 64'd0);
        check("t3_ferr", 64'(bus.frame_err), 64'h0);
        check("t3_wc", 64'(bus.word_count), 64'd2);

        // Bad stop bit: flagged, byte discarded, next four bytes form word 0.
        restart();
        send_byte(8'hAA, 1'b0);
        check("t4_ferr_set", 64'(bus.frame_err), 64'h1);
        send_word(32'h0403_0201);
        repeat (4) @(negedge clk);
        check("t4_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t4_addr", 64'(wa_q[0]), 64'h0);
            check("t4_data", 64'(wd_q[0]), 64'h0403_0201);
        end
        check("t4_wc", 64'(bus.word_count), 64'd1);
        check("t4_ferr_sticky", 64'(bus.frame_err), 64'h1);
        restart();
        check("t4_ferr_clr", 64'(bus.frame_err), 64'h0);
        check("t4_wc_clr", 64'(bus.word_count), 64'd0);

        // Five words: the 2-bit-address instance wraps and saturates its count.
        restart();
        for (int i = 0; i < 5; i++) send_word(32'hA0B0_C000 | 32'(i));
        repeat (4) @(negedge clk);
        check("t5_s_nwr", 64'(sa_q.size()), 64'd5);
        if (sa_q.size() == 5) begin
            check("t5_s_addr3", 64'(sa_q[3]), 64'd3);
            check("t5_s_addr4", 64'(sa_q[4]), 64'd0);
            check("t5_s_data4", 64'(sd_q[4]), 64'hA0B0_C004);
        end
        check("t5_s_ovf", 64'(bus_s.overflow), 64'h1);
        check("t5_s_wc", 64'(bus_s.word_count), 64'd4);
        check("t5_wc", 64'(bus.word_count), 64'd5);
        check("t5_ovf", 64'(bus.overflow), 64'h0);
        if (wa_q.size() == 5) check("t5_addr4", 64'(wa_q[4]), 64'd4);

        // Enable dropped after two bytes discards the partial word.
        restart();
        send_byte(8'h55); send_byte(8'h66);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_busy_off", 64'(bus.busy), 64'h0);
        enable = 1'b1;
        repeat (8) @(negedge clk);
        clear_logs();
        send_word(32'h0A0B_0C0D);
        repeat (4) @(negedge clk);
        check("t6_nwr", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t6_addr", 64'(wa_q[0]), 64'h0);
            check("t6_data", 64'(wd_q[0]), 64'h0A0B_0C0D);
        end
        check("t6_wc", 64'(bus.word_count), 64'd1);

        // Reset mid-frame, released while the line is still low.
        clear_logs();
        rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("t7_rst");
        repeat (CPB) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t7_nwr", 64'(wa_q.size()), 64'd0);
        check("t7_ferr", 64'(bus.frame_err), 64'h0);
        check("t7_wc", 64'(bus.word_count), 64'd0);
        send_word(32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        check("t7_nwr2", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) begin
            check("t7_addr", 64'(wa_q[0]), 64'h0);
            check("t7_data", 64'(wd_q[0]), 64'hCAFE_F00D);
        end
        diff = 0;
        check("t7_we_width", 64'(back2back), 64'(diff));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
